// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: op and FSM state encodings
// plus the default geometry and latency.
package dmem_pkg;

  localparam int DEPTH_DEF   = 128;
  localparam int LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_SWAP  = 2'd2,
    OP_RSVD  = 2'd3
  } dmem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: combinational read, synchronous write.
// Word i holds the value i at time zero; there is no reset of the contents.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  typedef logic [31:0] word_arr_t [DEPTH];

  function automatic word_arr_t init_words();
    word_arr_t w;
    for (int i = 0; i < DEPTH; i++) w[i] = 32'(i);
    return w;
  endfunction

  word_arr_t mem = init_words();

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed request-to-response latency.
// Define DMEM_SWAP_EN to enable the atomic SWAP op; otherwise SWAP returns an error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_RESP = ST_RESP;
  localparam logic [3:0] WAIT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

`ifdef DMEM_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic [1:0]  op_p0;
  logic [29:0] idx_p0;
  logic [31:0] wdata_p0;
  logic        accept;
  logic        enter_resp;
  logic [1:0]  cur_op;
  logic [29:0] cur_idx;
  logic [31:0] cur_wdata;
  logic        bad_req;
  logic        arr_we;
  logic [31:0] arr_rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  assign enter_resp = ((state == S_WAIT) && (wait_cnt == 4'd0)) ||
                      ((state == S_IDLE) && accept && (LATENCY == 1));

  // With LATENCY=1 the access happens on the accept edge itself, so the
  // request has to come straight from the ports rather than the latches.
  assign cur_op    = (state == S_IDLE) ? req_op          : op_p0;
  assign cur_idx   = (state == S_IDLE) ? req_addr[31:2]  : idx_p0;
  assign cur_wdata = (state == S_IDLE) ? req_wdata       : wdata_p0;

  assign bad_req = ({2'b00, cur_idx} >= 32'(DEPTH)) ||
                   (cur_op == OP_RSVD) ||
                   ((cur_op == OP_SWAP) && !SWAP_EN);

  // A reset on the edge that would enter RESP cancels the write.
  assign arr_we = enter_resp && rst && !bad_req &&
                  ((cur_op == OP_STORE) || (cur_op == OP_SWAP));

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (cur_idx[AW-1:0]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  // Stage p0: request capture
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0    <= req_op;
      idx_p0   <= req_addr[31:2];
      wdata_p0 <= req_wdata;
    end
  end

  // Stage p1: control FSM and registered response
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state <= S_RESP;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= bad_req;
        rsp_rdata <= (bad_req || (cur_op == OP_STORE)) ? 32'd0 : arr_rdata;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of 32-bit data words.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk  input  1  clock; reset rst, synchronous, active-low; clock clk.
REQ-004 SHALL have port rst  input  1  synchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_op  input  2  0 LOAD, 1 STORE, 2 SWAP, 3 reserved.
REQ-008 SHALL have port req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-009 SHALL have port req_wdata  input  32  store/swap data.
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  initiator accepts response.
REQ-012 SHALL have port rsp_rdata  output  32  read data.
REQ-013 SHALL have port rsp_err  output  1  request not performed.

Function
REQ-014 SHALL implement FSM IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-015 SHALL accept a request on a clk edge with req_valid&req_ready, latching op, word index and wdata.
REQ-016 SHALL go IDLE->RESP when LATENCY=1, else IDLE->WAIT, staying in WAIT for LATENCY-1 cycles, then WAIT->RESP; rsp_valid first high exactly LATENCY cycles after the accept edge.
REQ-017 SHALL perform the memory access on the edge entering RESP: LOAD reads, STORE writes, SWAP reads old word and writes wdata atomically.
REQ-018 SHALL drive rsp_rdata = word for LOAD, pre-write word for SWAP, 0 for STORE.
REQ-019 SHALL set rsp_err=1, rsp_rdata=0, no write, for word index >= DEPTH, op=3, or disabled SWAP.
REQ-020 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1; RESP->IDLE on that edge.
REQ-021 SHALL not accept a new request in the handshake cycle; next acceptance earliest one cycle after RESP->IDLE (throughput one per LATENCY+1 cycles).
REQ-022 SHALL ignore req_addr[1:0]; all accesses are full words.
REQ-023 SHALL initialise memory word i to value i at time zero; contents unaffected by rst.

Reset
REQ-024 SHALL, with rst=0 at an edge, enter IDLE, clear wait counter, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 after reset.
REQ-025 SHALL discard an in-flight request on reset in WAIT (no write); a reset in RESP leaves the already-committed write intact.

Configuration
REQ-026 SHALL, with DMEM_SWAP_EN defined, perform SWAP per REQ-017/018.
REQ-027 SHALL, without DMEM_SWAP_EN, treat op=2 as error per REQ-019 with identical timing.

Structure
REQ-028 SHALL place op encoding enum, FSM state enum, and DEPTH/LATENCY defaults in shared package dmem_pkg.
REQ-029 SHALL instantiate sub-module dmem_array: word array, combinational read, synchronous write enable.

Verification
REQ-030 Reset, LOAD addr 0x20 -> rsp_valid 2 cycles after accept, rsp_rdata=8, rsp_err=0.
REQ-031 STORE 0x1C wdata 0xDEADBEEF -> rsp_rdata=0; following LOAD 0x1C -> 0xDEADBEEF.
REQ-032 SWAP 0x08 wdata 0x55 -> with macro rsp_rdata=2, then LOAD 0x08 -> 0x55; without macro rsp_err=1, LOAD 0x08 -> 2.
REQ-033 LOAD/STORE 0x200 (index 128) -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-034 rsp_ready low 5 cycles with req_valid held high -> rsp outputs stable, req_ready=0, second request accepted one cycle after IDLE re-entry.
REQ-035 rst low during WAIT of STORE 0x10 wdata 0xFF -> rsp_valid=0 next cycle, LOAD 0x10 -> 4.
